// File: rtl/count_stream_checker.sv
// count_stream_checker
//   Watches a stream of up/down counter values and works out which way the
//   counter is stepping. After LOCK_COUNT consistent +1 or -1 steps it
//   declares lock. While locked, any sample that breaks the sequence raises
//   err and bumps err_cnt. Steps are measured between accepted samples, so
//   gaps in din_vld do not matter.
//
// Parameters
//   WIDTH      : counter value width (>= 2)
//   LOCK_COUNT : consistent steps needed to lock (1..15)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   din        : sampled counter value
//   din_vld    : din is taken this cycle
//   mode_out   : inferred direction, 1 = up, 0 = down
//   locked     : stream is tracking consistently
//   expect_val : next expected value (meaningful while locked)
//   err        : one-cycle pulse per sequence break while locked
//   err_cnt    : saturating break count

module count_stream_checker #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned LOCK_COUNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_vld,
   output logic             mode_out,
   output logic             locked,
   output logic [WIDTH-1:0] expect_val,
   output logic             err,
   output logic [7:0]       err_cnt
);

   localparam logic [3:0]       LockCnt = 4'(LOCK_COUNT);
   localparam logic [WIDTH-1:0] One     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MinusOne = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      StIdle,
      StAcq,
      StTrack,
      StLocked
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic             dir_q, dir_d;
   logic [3:0]       run_q, run_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0] expect_q, expect_d;
   logic             locked_q, locked_d;

   logic [WIDTH-1:0] delta;
   logic             step_up, step_dn, step_match, step_opp;
   logic [3:0]       run_inc;

   // Modular difference: wrap-around (e.g. 15 -> 0) is an ordinary +1 step.
   assign delta      = din - ref_q;
   assign step_up    = (delta == One);
   assign step_dn    = (delta == MinusOne);
   assign step_match = dir_q ? step_up : step_dn;
   assign step_opp   = dir_q ? step_dn : step_up;
   assign run_inc    = run_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      ref_d     = ref_q;
      dir_d     = dir_q;
      run_d     = run_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      if (din_vld) begin
         ref_d = din;
         unique case (state_q)
            StIdle: begin
               // First sample only seeds ref; no step to judge yet.
               state_d = StAcq;
            end
            StAcq: begin
               if (step_up || step_dn) begin
                  dir_d   = step_up;
                  run_d   = 4'd1;
                  state_d = (LockCnt == 4'd1) ? StLocked : StTrack;
               end
            end
            StTrack: begin
               if (step_match) begin
                  run_d = run_inc;
                  if (run_inc == LockCnt) begin
                     state_d = StLocked;
                  end
               end else if (step_opp) begin
                  dir_d = ~dir_q;
                  run_d = 4'd1;
               end else begin
                  run_d   = 4'd0;
                  state_d = StAcq;
               end
            end
            StLocked: begin
               if (!step_match) begin
                  err_d = 1'b1;
                  if (err_cnt_q != 8'hff) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
                  if (step_opp) begin
                     dir_d   = ~dir_q;
                     run_d   = 4'd1;
                     state_d = (LockCnt == 4'd1) ? StLocked : StTrack;
                  end else begin
                     run_d   = 4'd0;
                     state_d = StAcq;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      expect_d = dir_d ? (ref_d + One) : (ref_d - One);
      locked_d = (state_d == StLocked);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         ref_q     <= '0;
         dir_q     <= 1'b1;
         run_q     <= 4'd0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
         expect_q  <= One;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ref_q     <= ref_d;
         dir_q     <= dir_d;
         run_q     <= run_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         expect_q  <= expect_d;
         locked_q  <= locked_d;
      end
   end

   assign mode_out   = dir_q;
   assign locked     = locked_q;
   assign expect_val = expect_q;
   assign err        = err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker
//   Directed bench for count_stream_checker (WIDTH=4, LOCK_COUNT=3).
//   Inputs change on the falling edge; outputs are checked on the falling
//   edge after the rising edge that consumed the sample.

module tb_count_stream_checker;

   logic       clk;
   logic       rst;
   logic [3:0] din;
   logic       din_vld;
   logic       mode_out;
   logic       locked;
   logic [3:0] expect_val;
   logic       err;
   logic [7:0] err_cnt;

   int total = 0;
   int bad   = 0;
   int err_pulses = 0;

   count_stream_checker #(
      .WIDTH      (4),
      .LOCK_COUNT (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_vld    (din_vld),
      .mode_out   (mode_out),
      .locked     (locked),
      .expect_val (expect_val),
      .err        (err),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // err is high for whole cycles, so each pulse is seen once here.
   always @(negedge clk) begin
      if (err === 1'b1) err_pulses++;
   end

   task automatic send(input logic [3:0] v);
      @(negedge clk);
      din     = v;
      din_vld = 1'b1;
      @(posedge clk);
   endtask

   // One idle cycle; outputs seen here reflect the last accepted sample.
   task automatic idle();
      @(negedge clk);
      din_vld = 1'b0;
      din     = 4'hx;
   endtask

   task automatic do_reset();
      @(negedge clk);
      din_vld = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      rst     = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      #1;
      total++;
      if ({mode_out, locked, expect_val, err, err_cnt} !== {1'b1, 1'b0, 4'd1, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL reset_values: got mode=%b locked=%b exp=%0d err=%b cnt=%0d want 1 0 1 0 0",
                  mode_out, locked, expect_val, err, err_cnt);
      end
      rst = 1'b1;
   endtask

   task automatic test_up_lock();
      do_reset();
      send(4'd0); send(4'd1); send(4'd2);
      idle();
      total++;
      if (locked !== 1'b0) begin
         bad++;
         $display("FAIL up_lock_early: locked got %b want 0", locked);
      end
      send(4'd3);
      idle();
      total++;
      if ({locked, mode_out, expect_val, err_cnt} !== {1'b1, 1'b1, 4'd4, 8'd0}) begin
         bad++;
         $display("FAIL up_lock: got locked=%b mode=%b exp=%0d cnt=%0d want 1 1 4 0",
                  locked, mode_out, expect_val, err_cnt);
      end
   endtask

   task automatic test_wrap();
      int p0;
      do_reset();
      p0 = err_pulses;
      send(4'd13); send(4'd14); send(4'd15); send(4'd0); send(4'd1);
      idle();
      total++;
      if ({locked, mode_out, expect_val} !== {1'b1, 1'b1, 4'd2} || err_pulses != p0) begin
         bad++;
         $display("FAIL wrap_up: got locked=%b mode=%b exp=%0d errs=%0d want 1 1 2 0",
                  locked, mode_out, expect_val, err_pulses - p0);
      end
      do_reset();
      send(4'd2); send(4'd1); send(4'd0); send(4'd15); send(4'd14);
      idle();
      total++;
      if ({locked, mode_out, expect_val} !== {1'b1, 1'b0, 4'd13}) begin
         bad++;
         $display("FAIL wrap_down: got locked=%b mode=%b exp=%0d want 1 0 13",
                  locked, mode_out, expect_val);
      end
   endtask

   task automatic test_break();
      do_reset();
      send(4'd0); send(4'd1); send(4'd2); send(4'd3);
      send(4'd7);
      idle();
      total++;
      if ({err, err_cnt, locked} !== {1'b1, 8'd1, 1'b0}) begin
         bad++;
         $display("FAIL break_jump: got err=%b cnt=%0d locked=%b want 1 1 0", err, err_cnt, locked);
      end
      idle();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL break_pulse_width: err got %b want 0", err);
      end
      send(4'd8); send(4'd9); send(4'd10);
      idle();
      total++;
      if ({locked, expect_val} !== {1'b1, 4'd11}) begin
         bad++;
         $display("FAIL relock: got locked=%b exp=%0d want 1 11", locked, expect_val);
      end
      send(4'd10);
      idle();
      total++;
      if ({err, err_cnt, locked} !== {1'b1, 8'd2, 1'b0}) begin
         bad++;
         $display("FAIL break_repeat: got err=%b cnt=%0d locked=%b want 1 2 0", err, err_cnt, locked);
      end
   endtask

   task automatic test_reversal();
      do_reset();
      send(4'd2); send(4'd3); send(4'd4); send(4'd5);
      send(4'd4);
      idle();
      total++;
      if ({err, mode_out, locked, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
         bad++;
         $display("FAIL reverse: got err=%b mode=%b locked=%b cnt=%0d want 1 0 0 1",
                  err, mode_out, locked, err_cnt);
      end
      send(4'd3); send(4'd2);
      idle();
      total++;
      if ({locked, mode_out, expect_val} !== {1'b1, 1'b0, 4'd1}) begin
         bad++;
         $display("FAIL reverse_relock: got locked=%b mode=%b exp=%0d want 1 0 1",
                  locked, mode_out, expect_val);
      end
   endtask

   task automatic test_gaps();
      int gaps [3] = '{2, 5, 3};
      logic [3:0] exp_hold [3] = '{4'd1, 4'd2, 4'd3};
      int held_bad;
      do_reset();
      held_bad = 0;
      for (int s = 0; s < 3; s++) begin
         send(4'(s));
         for (int g = 0; g < gaps[s]; g++) begin
            idle();
            if (locked !== 1'b0 || expect_val !== exp_hold[s] || err !== 1'b0) held_bad++;
         end
      end
      total++;
      if (held_bad != 0) begin
         bad++;
         $display("FAIL gap_hold: %0d idle cycles with changed outputs, want 0", held_bad);
      end
      send(4'd3);
      idle();
      total++;
      if ({locked, expect_val} !== {1'b1, 4'd4}) begin
         bad++;
         $display("FAIL gap_lock: got locked=%b exp=%0d want 1 4", locked, expect_val);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] r;
      do_reset();
      send(4'd0); send(4'd1); send(4'd2); send(4'd3);
      r = 4'd3;
      for (int i = 1; i <= 300; i++) begin
         r = r + 4'd5;
         send(r);
         if (i == 100 || i == 300) begin
            idle();
            total++;
            if (err !== 1'b1 || err_cnt !== ((i == 100) ? 8'd100 : 8'd255)) begin
               bad++;
               $display("FAIL saturate_%0d: got err=%b cnt=%0d", i, err, err_cnt);
            end
         end
         r = r + 4'd1; send(r);
         r = r + 4'd1; send(r);
         r = r + 4'd1; send(r);
      end
      idle();
      total++;
      if ({locked, err_cnt} !== {1'b1, 8'd255}) begin
         bad++;
         $display("FAIL saturate_hold: got locked=%b cnt=%0d want 1 255", locked, err_cnt);
      end
   endtask

   task automatic test_async_reset();
      // Enters locked with err_cnt at 255 from the previous test.
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      total++;
      if ({mode_out, locked, expect_val, err, err_cnt} !== {1'b1, 1'b0, 4'd1, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL async_reset: got mode=%b locked=%b exp=%0d err=%b cnt=%0d want 1 0 1 0 0",
                  mode_out, locked, expect_val, err, err_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      send(4'd4); send(4'd5); send(4'd6); send(4'd7);
      idle();
      total++;
      if ({locked, expect_val, err_cnt} !== {1'b1, 4'd8, 8'd0}) begin
         bad++;
         $display("FAIL post_reset_lock: got locked=%b exp=%0d cnt=%0d want 1 8 0",
                  locked, expect_val, err_cnt);
      end
   endtask

   initial begin
      rst     = 1'b0;
      din     = 4'd0;
      din_vld = 1'b0;
      test_reset();
      test_up_lock();
      test_wrap();
      test_break();
      test_reversal();
      test_gaps();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
